// File: rtl/mcu_pkg.sv
// Shared MCU datapath definitions used by the sequential multiplier.
//   - MUL_OP_* : operation codes presented on the multiplier's op input
//   - RES_SRC_*: writeback result-select codes (d2 is the multiplier)
//   - mul_state_t: multiplier controller state encoding
//   - mul_op_high(): true when the op returns the high product word
package mcu_pkg;

  localparam logic [1:0] MUL_OP_MUL     = 2'b00;  // low word
  localparam logic [1:0] MUL_OP_MULH    = 2'b01;  // signed x signed, high word
  localparam logic [1:0] MUL_OP_MULHU   = 2'b10;  // unsigned x unsigned, high word
  localparam logic [1:0] MUL_OP_MUL_ALT = 2'b11;  // alias of MUL

  localparam logic [1:0] RES_SRC_NONE = 2'b00;
  localparam logic [1:0] RES_SRC_MUL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  function automatic logic mul_op_high(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHU);
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle of the sequential multiplier.
//   master: controller side (drives start/op/a/b, observes status and result)
//   slave : multiplier side
//   start, op[1:0], a/b[WIDTH-1:0]          request and operands
//   busy, done, result[WIDTH-1:0], res_src  status, product and writeback select
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       res_src;

  modport master (
    output start, op, a, b,
    input  busy, done, result, res_src
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, res_src
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// A request is accepted only in IDLE; the operation then runs for WIDTH
// cycles (busy high), followed by a single DONE cycle in which done pulses,
// result is updated and res_src selects the multiplier for writeback.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous reset, active-high
//   bus    mul_seq_if.slave (start/op/a/b in; busy/done/result/res_src out)
module mul_seq
  import mcu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mul_seq_if.slave    bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_t         state_reg;
  logic [1:0]         op_reg;
  logic               neg_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [1:0]         res_src_reg;

  logic [WIDTH:0]     sum_next;
  logic [2*WIDTH-1:0] shift_next;
  logic [2*WIDTH-1:0] final_next;
  logic               last_iter;

  // Magnitude of a signed operand; the most negative value maps to itself,
  // which is exactly right when read back as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (-v) : v;
  endfunction

  always_comb begin
    // Keep the carry: the sum is WIDTH+1 bits wide and becomes the new top
    // of the accumulator after the right shift.
    sum_next   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                 (mplier_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    shift_next = {sum_next, acc_reg[WIDTH-1:1]};
    // Sign correction for MULH is applied to the full double-width product.
    final_next = neg_reg ? (-shift_next) : shift_next;
    last_iter  = (cnt_reg == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      op_reg      <= MUL_OP_MUL;
      neg_reg     <= 1'b0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      res_src_reg <= RES_SRC_NONE;
    end else begin
      done_reg    <= 1'b0;
      res_src_reg <= RES_SRC_NONE;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            op_reg <= bus.op;
            if (bus.op == MUL_OP_MULH) begin
              mcand_reg  <= magnitude(bus.a);
              mplier_reg <= magnitude(bus.b);
              neg_reg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            end else begin
              mcand_reg  <= bus.a;
              mplier_reg <= bus.b;
              neg_reg    <= 1'b0;
            end
            acc_reg   <= '0;
            cnt_reg   <= CW'(WIDTH);
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg - CW'(1);
          if (last_iter) begin
            // Final iteration, sign fix-up and word select share one edge so
            // done appears exactly WIDTH+1 cycles after the start edge.
            acc_reg     <= final_next;
            result_reg  <= mul_op_high(op_reg) ? final_next[2*WIDTH-1:WIDTH]
                                               : final_next[WIDTH-1:0];
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            res_src_reg <= RES_SRC_MUL;
            state_reg   <= ST_DONE;
          end else begin
            acc_reg <= shift_next;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.result  = result_reg;
  assign bus.res_src = res_src_reg;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq (WIDTH = 32): directed scenarios plus
// random operations checked against a plain-arithmetic product model.
module tb_mul_seq;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full 64-bit products, then the word the op asks for.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [2*W-1:0] sp;
    logic        [2*W-1:0] up;
    sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'b01:   return sp[2*W-1:W];
      2'b10:   return up[2*W-1:W];
      default: return up[W-1:0];
    endcase
  endfunction

  // Launch one op and observe it until done (bounded). Cycle k is the clock
  // period after the k-th edge following the start edge (edge 0).
  // pulse_cyc > 0 re-asserts start with a=b=1 during that cycle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int pulse_cyc,
                        output int done_cyc, output logic [W-1:0] res,
                        output int busy_cnt, output bit src_bad);
    done_cyc = -1;
    res      = '0;
    busy_cnt = 0;
    src_bad  = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    for (int k = 1; k <= 100 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc = k;
        res      = bus.result;
        if (bus.res_src !== 2'b10) src_bad = 1'b1;
      end else if (bus.res_src !== 2'b00) begin
        src_bad = 1'b1;
      end
      if (k == pulse_cyc) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    $display("op=%0d a=%h b=%h done_cycle=%0d result=%h", op, a, b, done_cyc, res);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.res_src !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b result=%h res_src=%b, required 0 0 0 00",
               bus.busy, bus.done, bus.result, bus.res_src);
    end
    $display("reset state checked");
  endtask

  task automatic test_basic();
    int d; logic [W-1:0] r; int bc; bit sb;
    run_op(2'b00, 32'd6, 32'd7, 0, d, r, bc, sb);
    n_cmp++;
    if (d !== 33) begin n_bad++; $display("FAIL basic_latency: done cycle %0d, required 33", d); end
    n_cmp++;
    if (bc !== 32) begin n_bad++; $display("FAIL basic_busy: busy cycles %0d, required 32", bc); end
    n_cmp++;
    if (r !== 32'd42) begin n_bad++; $display("FAIL basic_result: %h, required %h", r, 32'd42); end
    n_cmp++;
    if (sb) begin n_bad++; $display("FAIL basic_res_src: res_src wrong in some cycle, required 10 only with done"); end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.result !== 32'd42 || bus.res_src !== 2'b00) begin
      n_bad++;
      $display("FAIL basic_hold: done=%b result=%h res_src=%b, required 0 %h 00",
               bus.done, bus.result, bus.res_src, 32'd42);
    end
  endtask

  task automatic test_signed();
    int d; logic [W-1:0] r; int bc; bit sb;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d, r, bc, sb);
    n_cmp++;
    if (r !== 32'h0000_0000) begin n_bad++; $display("FAIL mulh_m1m1: %h, required 00000000", r); end
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d, r, bc, sb);
    n_cmp++;
    if (r !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mulhu_m1m1: %h, required fffffffe", r); end
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, d, r, bc, sb);
    n_cmp++;
    if (r !== 32'h4000_0000) begin n_bad++; $display("FAIL mulh_min_min: %h, required 40000000", r); end
    run_op(2'b01, 32'h8000_0000, 32'd1, 0, d, r, bc, sb);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mulh_min_one: %h, required ffffffff", r); end
  endtask

  task automatic test_ignore_start();
    int d; logic [W-1:0] r; int bc; bit sb;
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 10, d, r, bc, sb);
    n_cmp++;
    if (r !== 32'h242D_2080) begin n_bad++; $display("FAIL ignore_start_result: %h, required 242d2080", r); end
    n_cmp++;
    if (d !== 33) begin n_bad++; $display("FAIL ignore_start_latency: done cycle %0d, required 33", d); end
  endtask

  task automatic test_reset_mid_run();
    int d; logic [W-1:0] r; int bc; bit sb; bit saw_done;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd1000; bus.b = 32'd1000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_run_busy: busy=%b, required 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
      n_bad++;
      $display("FAIL mid_run_reset: busy=%b done=%b result=%h, required 0 0 0",
               bus.busy, bus.done, bus.result);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin n_bad++; $display("FAIL mid_run_no_done: done=1 seen, required 0 for 40 cycles"); end
    run_op(2'b00, 32'd3, 32'd5, 0, d, r, bc, sb);
    n_cmp++;
    if (r !== 32'd15) begin n_bad++; $display("FAIL after_reset_op: %h, required %h", r, 32'd15); end
    // reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_same: busy=%b, required 0", bus.busy); end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_after: busy=%b, required 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int dc[$]; logic [W-1:0] rs[$]; int gap;
    gap = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3;
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      if (bus.done) begin dc.push_back(k); rs.push_back(bus.result); end
      else if (!bus.busy && dc.size() == 1) gap++;
      if (k == 68) bus.start = 1'b0;
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (dc.size() != 2 || dc[0] != 33 || dc[1] != 67) begin
      n_bad++;
      $display("FAIL b2b_done_cycles: %0d pulses first=%0d, required 2 pulses at 33 and 67",
               dc.size(), (dc.size() > 0) ? dc[0] : -1);
    end
    n_cmp++;
    if (rs.size() != 2 || rs[0] !== 32'd6 || rs[1] !== 32'd6) begin
      n_bad++;
      $display("FAIL b2b_results: %0d results, first=%h, required two of %h",
               rs.size(), (rs.size() > 0) ? rs[0] : 32'd0, 32'd6);
    end
    n_cmp++;
    if (gap != 1) begin n_bad++; $display("FAIL b2b_idle_gap: %0d idle cycles, required 1", gap); end
    $display("back-to-back: pulses=%0d idle_gap=%0d", dc.size(), gap);
  endtask

  task automatic test_random();
    int d; logic [W-1:0] r; int bc; bit sb;
    logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp_r;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i == 0) a = '0;
      if (i == 1) b = '0;
      if (i == 2) begin op = 2'b01; a = 32'h8000_0000; end
      if (i == 3) begin op = 2'b01; b = 32'h8000_0000; end
      exp_r = ref_mul(op, a, b);
      run_op(op, a, b, 0, d, r, bc, sb);
      n_cmp++;
      if (r !== exp_r) begin
        n_bad++;
        $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h, required %h", i, op, a, b, r, exp_r);
      end
      n_cmp++;
      if (d !== 33 || bc !== 32 || sb) begin
        n_bad++;
        $display("FAIL rand_timing[%0d]: done cycle %0d busy %0d src_bad %0d, required 33 32 0",
                 i, d, bc, sb);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_signed();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
